ru_write_ctrl: RTL and testbench

- Owns the register-unit write port: every write to the 32x32 register file passes through this block.
- After reset, a sequencer writes x1..x31 over the write port:
  - SP_INIT into SP_IDX (x2, stack pointer).
  - 0 into every other register.
- After that, it arbitrates the write port between the writeback stage (fixed high priority) and a debug/loader write port (valid/ack).
- A starvation guard requests a pipeline bubble so the debug port always makes progress.

---
 rtl/ru_write_ctrl_if.sv | 27 ++
 rtl/ru_write_ctrl.sv | 132 +++++++++++++
 tb/tb_ru_write_ctrl.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ru_write_ctrl_if.sv
// Write-port bundle between the register-unit write controller and its clients.
// Latency: none; wires only.
// Backpressure: debug side is valid/ack (dbg_req held until dbg_ack); writeback and RU side have none.
//   slave  : controller view (consumes wb_*/dbg_* requests, drives dbg_ack and ru_*)
//   master : environment view (drives wb_*/dbg_* requests, observes dbg_ack and ru_*)
interface ru_write_ctrl_if;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        dbg_req;
    logic [4:0]  dbg_rd;
    logic [31:0] dbg_data;
    logic        dbg_ack;
    logic        ru_we;
    logic [4:0]  ru_rd;
    logic [31:0] ru_data;

    modport slave (
        input  wb_we, wb_rd, wb_data, dbg_req, dbg_rd, dbg_data,
        output dbg_ack, ru_we, ru_rd, ru_data
    );

    modport master (
        output wb_we, wb_rd, wb_data, dbg_req, dbg_rd, dbg_data,
        input  dbg_ack, ru_we, ru_rd, ru_data
    );
endinterface

// File: rtl/ru_write_ctrl.sv
// Register-unit write port owner: post-reset init of x1..x31, then writeback/debug arbitration.
// Latency: ru_* and dbg_ack are combinational from state and inputs; init_done/stall_o/err_o are registered.
// Backpressure: debug waits (dbg_ack low) behind writeback; starvation raises stall_o to force a bubble.
//   clk, rst_n : clock and synchronous active-low reset
//   bus        : wb_* / dbg_* requests in, dbg_ack and ru_* write port out
//   init_done  : high once x1..x31 have been initialised
//   stall_o    : asks the pipeline to hold writeback (init, starvation)
//   err_o      : sticky, writeback attempted while stall_o was high
module ru_write_ctrl #(
    parameter logic [4:0]  SP_IDX     = 5'd2,
    parameter logic [31:0] SP_INIT    = 32'h0000_0200,
    parameter int unsigned STARVE_LIM = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    ru_write_ctrl_if.slave   bus,
    output logic             init_done,
    output logic             stall_o,
    output logic             err_o
);

    localparam logic [7:0] LIM = 8'(STARVE_LIM);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t      state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic [7:0]  starve_cnt_q, starve_cnt_d;
    logic        err_q, err_d;
    logic        init_done_q, init_done_d;
    logic        stall_q, stall_d;

    logic        wb_hit;
    logic        dbg_grant;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        starve_cnt_d = starve_cnt_q;
        err_d        = err_q;
        init_done_d  = init_done_q;
        stall_d      = stall_q;
        dbg_grant    = 1'b0;
        bus.ru_we    = 1'b0;
        bus.ru_rd    = 5'd0;
        bus.ru_data  = 32'd0;

        // A write to x0 is not a real writeback, so it must not block debug.
        wb_hit = bus.wb_we && (bus.wb_rd != 5'd0);

        // stall_q is high for all of INIT, so this also flags writebacks during init.
        if (bus.wb_we && stall_q) begin
            err_d = 1'b1;
        end

        case (state_q)
            ST_INIT: begin
                bus.ru_we   = 1'b1;
                bus.ru_rd   = idx_q;
                bus.ru_data = (idx_q == SP_IDX) ? SP_INIT : 32'd0;
                idx_d       = idx_q + 5'd1;
                if (idx_q == 5'd31) begin
                    state_d     = ST_RUN;
                    init_done_d = 1'b1;
                    stall_d     = 1'b0;
                end
            end
            ST_RUN: begin
                if (wb_hit) begin
                    bus.ru_we   = 1'b1;
                    bus.ru_rd   = bus.wb_rd;
                    bus.ru_data = bus.wb_data;
                end else if (bus.dbg_req) begin
                    // Debug writes to x0 are acknowledged but dropped.
                    dbg_grant   = 1'b1;
                    bus.ru_we   = (bus.dbg_rd != 5'd0);
                    bus.ru_rd   = bus.dbg_rd;
                    bus.ru_data = bus.dbg_data;
                end

                if (!bus.dbg_req || dbg_grant) begin
                    starve_cnt_d = 8'd0;
                end else if (starve_cnt_q != LIM) begin
                    starve_cnt_d = starve_cnt_q + 8'd1;
                end

                // Stall rises on the edge where the blocked count hits the limit
                // and drops on the edge after the grant.
                if (dbg_grant) begin
                    stall_d = 1'b0;
                end else if (starve_cnt_d == LIM) begin
                    stall_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase

        if (!rst_n) begin
            bus.ru_we   = 1'b0;
            bus.ru_rd   = 5'd0;
            bus.ru_data = 32'd0;
            dbg_grant   = 1'b0;
        end

        bus.dbg_ack = dbg_grant;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_INIT;
            idx_q        <= 5'd1;
            starve_cnt_q <= 8'd0;
            err_q        <= 1'b0;
            init_done_q  <= 1'b0;
            stall_q      <= 1'b1;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            starve_cnt_q <= starve_cnt_d;
            err_q        <= err_d;
            init_done_q  <= init_done_d;
            stall_q      <= stall_d;
        end
    end

    assign init_done = init_done_q;
    assign stall_o   = stall_q;
    assign err_o     = err_q;

endmodule

// File: tb/tb_ru_write_ctrl.sv
// Testbench for ru_write_ctrl: directed scenarios plus a randomized run against a behavioural model.
// Latency: n/a.
// Backpressure: debug requester holds dbg_req until dbg_ack; writeback honours stall_o.
module tb_ru_write_ctrl;

    localparam int LIM = 8;

    logic clk;
    logic rst_n;
    logic init_done;
    logic stall_o;
    logic err_o;

    int checks = 0;
    int errors = 0;

    // Register unit model: 32 entries written on the falling edge, no x0 guard,
    // so any stray x0 write from the controller becomes visible.
    logic [31:0] rf [32] = '{default: 32'h0};

    ru_write_ctrl_if bus ();

    ru_write_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .init_done (init_done),
        .stall_o   (stall_o),
        .err_o     (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.ru_we === 1'b1) rf[bus.ru_rd] <= bus.ru_data;
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.wb_we    = 1'b0;
        bus.wb_rd    = 5'd0;
        bus.wb_data  = 32'd0;
        bus.dbg_req  = 1'b0;
        bus.dbg_rd   = 5'd0;
        bus.dbg_data = 32'd0;
    endtask

    task automatic test_reset();
        idle_inputs();
        // A debug request waits through reset and init, granted in the first RUN cycle.
        bus.dbg_req  = 1'b1;
        bus.dbg_rd   = 5'd20;
        bus.dbg_data = 32'h77;
        rst_n = 1'b0;
        next_cycle();
        next_cycle();
        @(negedge clk);
        checks++; if (bus.ru_we !== 1'b0) begin errors++; $display("FAIL rst_ru_we got=%0b exp=0", bus.ru_we); end
        checks++; if (bus.dbg_ack !== 1'b0) begin errors++; $display("FAIL rst_dbg_ack got=%0b exp=0", bus.dbg_ack); end
        checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL rst_stall got=%0b exp=1", stall_o); end
        checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL rst_init_done got=%0b exp=0", init_done); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL rst_err got=%0b exp=0", err_o); end
        next_cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_init();
        logic [31:0] exp_d;
        for (int i = 1; i <= 31; i++) begin
            @(negedge clk);
            exp_d = (i == 2) ? 32'h200 : 32'h0;
            checks++; if (bus.ru_we !== 1'b1) begin errors++; $display("FAIL init_we idx=%0d got=%0b exp=1", i, bus.ru_we); end
            checks++; if (bus.ru_rd !== 5'(i)) begin errors++; $display("FAIL init_rd got=%0d exp=%0d", bus.ru_rd, i); end
            checks++; if (bus.ru_data !== exp_d) begin errors++; $display("FAIL init_data idx=%0d got=%0h exp=%0h", i, bus.ru_data, exp_d); end
            checks++; if (bus.dbg_ack !== 1'b0) begin errors++; $display("FAIL init_dbg_ack idx=%0d got=%0b exp=0", i, bus.dbg_ack); end
            checks++; if (stall_o !== 1'b1 || init_done !== 1'b0) begin errors++; $display("FAIL init_status idx=%0d got stall=%0b done=%0b exp stall=1 done=0", i, stall_o, init_done); end
            next_cycle();
        end
        @(negedge clk);
        checks++; if (init_done !== 1'b1) begin errors++; $display("FAIL run_init_done got=%0b exp=1", init_done); end
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL run_stall got=%0b exp=0", stall_o); end
        checks++; if (bus.dbg_ack !== 1'b1 || bus.ru_we !== 1'b1 || bus.ru_rd !== 5'd20) begin errors++; $display("FAIL first_dbg_grant got ack=%0b we=%0b rd=%0d exp ack=1 we=1 rd=20", bus.dbg_ack, bus.ru_we, bus.ru_rd); end
        next_cycle();
        bus.dbg_req = 1'b0;
        @(negedge clk);
        checks++; if (rf[2] !== 32'h200) begin errors++; $display("FAIL read_x2 got=%0h exp=200", rf[2]); end
        checks++; if (rf[5] !== 32'h0) begin errors++; $display("FAIL read_x5 got=%0h exp=0", rf[5]); end
        checks++; if (rf[20] !== 32'h77) begin errors++; $display("FAIL read_x20 got=%0h exp=77", rf[20]); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL init_err got=%0b exp=0", err_o); end
        next_cycle();
    endtask

    task automatic test_wb_priority();
        bus.wb_we = 1'b1; bus.wb_rd = 5'd7; bus.wb_data = 32'hDEADBEEF;
        bus.dbg_req = 1'b1; bus.dbg_rd = 5'd9; bus.dbg_data = 32'hA5A5_0009;
        @(negedge clk);
        checks++; if (bus.ru_we !== 1'b1 || bus.ru_rd !== 5'd7 || bus.ru_data !== 32'hDEADBEEF) begin errors++; $display("FAIL prio_wb_write got we=%0b rd=%0d data=%0h exp we=1 rd=7 data=deadbeef", bus.ru_we, bus.ru_rd, bus.ru_data); end
        checks++; if (bus.dbg_ack !== 1'b0) begin errors++; $display("FAIL prio_dbg_blocked got=%0b exp=0", bus.dbg_ack); end
        next_cycle();
        bus.wb_we = 1'b0;
        @(negedge clk);
        checks++; if (bus.dbg_ack !== 1'b1 || bus.ru_we !== 1'b1 || bus.ru_rd !== 5'd9 || bus.ru_data !== 32'hA5A5_0009) begin errors++; $display("FAIL prio_dbg_grant got ack=%0b we=%0b rd=%0d data=%0h exp ack=1 we=1 rd=9 data=a5a50009", bus.dbg_ack, bus.ru_we, bus.ru_rd, bus.ru_data); end
        next_cycle();
        bus.dbg_req = 1'b0;
        @(negedge clk);
        checks++; if (bus.ru_we !== 1'b0 || bus.ru_rd !== 5'd0 || bus.ru_data !== 32'd0) begin errors++; $display("FAIL idle_outputs got we=%0b rd=%0d data=%0h exp all 0", bus.ru_we, bus.ru_rd, bus.ru_data); end
        checks++; if (rf[7] !== 32'hDEADBEEF || rf[9] !== 32'hA5A5_0009) begin errors++; $display("FAIL prio_reads got x7=%0h x9=%0h exp deadbeef a5a50009", rf[7], rf[9]); end
        next_cycle();
    endtask

    task automatic test_starvation();
        int  n = 0;
        bit  stalled = 0;
        bus.dbg_req = 1'b1; bus.dbg_rd = 5'd11; bus.dbg_data = 32'h5555;
        bus.wb_rd = 5'd3;
        for (int c = 0; c < 20 && !stalled; c++) begin
            if (stall_o === 1'b1) begin
                stalled = 1;
                bus.wb_we = 1'b0;
            end else begin
                bus.wb_we = 1'b1;
                bus.wb_data = $urandom;
                @(negedge clk);
                checks++; if (bus.dbg_ack !== 1'b0) begin errors++; $display("FAIL starve_blocked cyc=%0d got ack=%0b exp=0", c, bus.dbg_ack); end
                n++;
                next_cycle();
            end
        end
        checks++; if (n != LIM) begin errors++; $display("FAIL starve_cycles got=%0d exp=%0d", n, LIM); end
        @(negedge clk);
        checks++; if (bus.dbg_ack !== 1'b1 || bus.ru_rd !== 5'd11) begin errors++; $display("FAIL starve_grant got ack=%0b rd=%0d exp ack=1 rd=11", bus.dbg_ack, bus.ru_rd); end
        checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL starve_stall_at_grant got=%0b exp=1", stall_o); end
        next_cycle();
        bus.dbg_req = 1'b0;
        @(negedge clk);
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL starve_stall_release got=%0b exp=0", stall_o); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL starve_err got=%0b exp=0", err_o); end
        next_cycle();
    endtask

    task automatic test_dbg_x0();
        bus.dbg_req = 1'b1; bus.dbg_rd = 5'd0; bus.dbg_data = 32'h1234;
        @(negedge clk);
        checks++; if (bus.dbg_ack !== 1'b1 || bus.ru_we !== 1'b0) begin errors++; $display("FAIL dbg_x0 got ack=%0b we=%0b exp ack=1 we=0", bus.dbg_ack, bus.ru_we); end
        next_cycle();
        // Writeback to x0 does not block the debug port.
        bus.wb_we = 1'b1; bus.wb_rd = 5'd0; bus.wb_data = 32'hFFFF;
        bus.dbg_rd = 5'd13; bus.dbg_data = 32'h1313;
        @(negedge clk);
        checks++; if (bus.dbg_ack !== 1'b1 || bus.ru_rd !== 5'd13 || bus.ru_data !== 32'h1313) begin errors++; $display("FAIL wb_x0_dbg got ack=%0b rd=%0d data=%0h exp ack=1 rd=13 data=1313", bus.dbg_ack, bus.ru_rd, bus.ru_data); end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        checks++; if (rf[0] !== 32'h0) begin errors++; $display("FAIL read_x0 got=%0h exp=0", rf[0]); end
        next_cycle();
    endtask

    task automatic test_random();
        int          blk = 0;
        bit          stl = 0;
        bit          pend = 0;
        bit          last_ack = 0;
        bit          wb_wins, e_ack, e_we;
        logic [4:0]  e_rd;
        logic [31:0] e_dat;
        logic [31:0] exp_rf [32];
        bit          written [32];
        for (int i = 0; i < 32; i++) begin written[i] = 0; exp_rf[i] = 32'h0; end
        for (int c = 0; c < 400; c++) begin
            if (last_ack) begin pend = 0; bus.dbg_req = 1'b0; end
            if (!pend && $urandom_range(1, 0) == 1) begin
                pend = 1;
                bus.dbg_req  = 1'b1;
                bus.dbg_rd   = 5'($urandom_range(31, 0));
                bus.dbg_data = $urandom;
            end
            bus.wb_we   = stl ? 1'b0 : ($urandom_range(3, 0) != 0);
            bus.wb_rd   = 5'($urandom_range(31, 0));
            bus.wb_data = $urandom;

            wb_wins = bus.wb_we && (bus.wb_rd != 5'd0);
            e_ack   = pend && !wb_wins;
            e_we    = wb_wins || (e_ack && bus.dbg_rd != 5'd0);
            e_rd    = wb_wins ? bus.wb_rd : bus.dbg_rd;
            e_dat   = wb_wins ? bus.wb_data : bus.dbg_data;

            @(negedge clk);
            checks++; if (stall_o !== stl) begin errors++; $display("FAIL rnd_stall cyc=%0d got=%0b exp=%0b", c, stall_o, stl); end
            checks++; if (bus.dbg_ack !== e_ack) begin errors++; $display("FAIL rnd_ack cyc=%0d got=%0b exp=%0b", c, bus.dbg_ack, e_ack); end
            checks++; if (bus.ru_we !== e_we) begin errors++; $display("FAIL rnd_we cyc=%0d got=%0b exp=%0b", c, bus.ru_we, e_we); end
            if (e_we) begin
                checks++; if (bus.ru_rd !== e_rd || bus.ru_data !== e_dat) begin errors++; $display("FAIL rnd_write cyc=%0d got rd=%0d data=%0h exp rd=%0d data=%0h", c, bus.ru_rd, bus.ru_data, e_rd, e_dat); end
                exp_rf[e_rd] = e_dat;
                written[e_rd] = 1;
            end
            checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL rnd_err cyc=%0d got=%0b exp=0", c, err_o); end

            // Stall follows once the debug request has been blocked LIM cycles in a row,
            // and clears the cycle after the grant.
            blk      = (pend && !e_ack) ? blk + 1 : 0;
            stl      = e_ack ? 1'b0 : (stl || blk >= LIM);
            last_ack = e_ack;
            next_cycle();
        end
        idle_inputs();
        next_cycle();
        for (int i = 0; i < 32; i++) begin
            if (written[i]) begin
                checks++; if (rf[i] !== exp_rf[i]) begin errors++; $display("FAIL rnd_read x%0d got=%0h exp=%0h", i, rf[i], exp_rf[i]); end
            end
        end
    endtask

    task automatic test_reset_mid_init();
        idle_inputs();
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        for (int i = 1; i <= 14; i++) next_cycle();
        @(negedge clk);
        checks++; if (bus.ru_rd !== 5'd15) begin errors++; $display("FAIL mid_init_pos got=%0d exp=15", bus.ru_rd); end
        next_cycle();
        // Reset lands while idx=16 is being presented; init must restart from 1.
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (bus.ru_we !== 1'b0) begin errors++; $display("FAIL mid_rst_we got=%0b exp=0", bus.ru_we); end
        next_cycle();
        rst_n = 1'b1;
        for (int i = 1; i <= 31; i++) begin
            if (i == 10) begin bus.wb_we = 1'b1; bus.wb_rd = 5'd6; bus.wb_data = 32'hBAD; end
            else         begin bus.wb_we = 1'b0; end
            @(negedge clk);
            checks++; if (bus.ru_rd !== 5'(i) || bus.ru_we !== 1'b1) begin errors++; $display("FAIL reinit_rd got=%0d we=%0b exp=%0d we=1", bus.ru_rd, bus.ru_we, i); end
            checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL reinit_done idx=%0d got=%0b exp=0", i, init_done); end
            if (i > 10) begin
                checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL init_wb_err idx=%0d got=%0b exp=1", i, err_o); end
            end
            next_cycle();
        end
        bus.wb_we = 1'b0;
        @(negedge clk);
        checks++; if (init_done !== 1'b1 || stall_o !== 1'b0) begin errors++; $display("FAIL reinit_run got done=%0b stall=%0b exp done=1 stall=0", init_done, stall_o); end
        next_cycle();
        next_cycle();
        @(negedge clk);
        checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL err_sticky got=%0b exp=1", err_o); end
        checks++; if (rf[6] !== 32'h0) begin errors++; $display("FAIL dropped_wb_x6 got=%0h exp=0", rf[6]); end
        next_cycle();
        rst_n = 1'b0;
        next_cycle();
        @(negedge clk);
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL err_cleared got=%0b exp=0", err_o); end
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_init();
        test_wb_priority();
        test_starvation();
        test_dbg_x0();
        test_random();
        test_reset_mid_init();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
